dnn_input_buffer: RTL
=====================

DNN_INPUT_BUFFER -- requirements
Module: dnn_input_buffer

Interface
REQ-001 Parameter OBIT, default 13: width of one normalized word.
REQ-002 Parameter INFRAME, default 5: frames per context window.
REQ-003 Parameter IDIM, default 26: coefficients per frame.
REQ-004 Parameter DEPTH, default INFRAME*IDIM (130): words per window (one bank).
REQ-005 Parameter AW, default 8: read-address width, with 2^AW >= DEPTH.
REQ-006 Port clk, input, 1: the only clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port dv_i, input, 1: word valid from the normalizer.
REQ-009 Port vec_i, input, OBIT, signed: normalized word.
REQ-010 Port rd_addr, input, AW: word address in the ready window, frame*IDIM+dim.
REQ-011 Port rd_en, input, 1: read strobe.
REQ-012 Port rd_data, output, OBIT, signed: read result.
REQ-013 Port win_rdy, output, 1: a complete window is readable.
REQ-014 Port rd_done, input, 1: one-cycle pulse from the consumer that releases the readable window.
REQ-015 Port ovf, output, 1: sticky flag set when words are dropped.
REQ-016 Port short_err, output, 1: one-cycle pulse when a burst is truncated.

Function
REQ-017 Input protocol: a window is one contiguous burst with dv_i high for DEPTH consecutive cycles, one word per cycle, in frame-major order.
REQ-018 Storage is two banks (ping-pong) of DEPTH x OBIT; wr_bank and rd_bank are 1-bit pointers, and each bank has a full flag.
REQ-019 Write FSM states: W_IDLE, W_FILL, W_DROP.
REQ-020 In W_IDLE or W_FILL, dv_i=1 with wr_bank not full writes vec_i at wr_cnt and increments wr_cnt, entering or staying in W_FILL.
REQ-021 When the word at wr_cnt=DEPTH-1 is written, the buffer sets full[wr_bank], toggles wr_bank, clears wr_cnt and returns to W_IDLE in that same edge.
REQ-022 If dv_i=1 while full[wr_bank]=1, the word is not written, ovf is set, and the FSM enters W_DROP.
REQ-023 W_DROP discards words until dv_i=0, then returns to W_IDLE; a partially dropped burst is never stored.
REQ-024 If dv_i falls in W_FILL with 0 < wr_cnt < DEPTH, wr_cnt clears, the bank stays not full, short_err pulses for 1 cycle, and the FSM returns to W_IDLE.
REQ-025 win_rdy = full[rd_bank], registered.
REQ-026 win_rdy rises 1 cycle after the edge that fills the bank.
REQ-027 rd_en=1 returns the word of bank rd_bank at rd_addr on rd_data at the next edge (1-cycle latency).
REQ-028 rd_data holds its value when rd_en=0.
REQ-029 rd_addr >= DEPTH returns 0.
REQ-030 rd_en while win_rdy=0 returns 0.
REQ-031 rd_done with win_rdy=1 clears full[rd_bank] and toggles rd_bank.
REQ-032 rd_done with win_rdy=0 is ignored.
REQ-033 rd_done and bank-fill completion on the same edge are both applied; ordering is preserved, so the oldest full bank is always the one read.
REQ-034 rd_done on the same edge as a dv_i word, with both banks full, frees a bank; that word is still dropped (ovf set), and the next burst is accepted.
REQ-035 Windows are non-overlapping: each DEPTH-word burst is one window, and no sliding reuse is performed.

Reset
REQ-036 rst=1 at a clock edge forces: W_IDLE, wr_cnt=0, wr_bank=0, rd_bank=0, both full flags=0, win_rdy=0, rd_data=0, ovf=0, short_err=0.
REQ-037 Reset mid-burst discards the partial window; words with dv_i=1 after reset releases start a fresh window at wr_cnt=0.
REQ-038 Memory contents are not reset.
REQ-039 Only rst clears ovf.

Structure
REQ-040 OBIT, INFRAME, IDIM, DEPTH and the write-FSM state encodings live in the shared DNN front-end package, alongside the normalizer widths.
REQ-041 One sub-module, dp_ram_1r1w (simple dual-port, 1-cycle registered read, 2*DEPTH x OBIT), is instantiated.
REQ-042 dp_ram_1r1w addresses are {bank, word}.

Verification
REQ-043 One 130-word burst with vec_i=k-65 (k=0..129) -> win_rdy=1 one cycle after the last word; rd_addr=0 gives -65, rd_addr=129 gives 64, and rd_addr=130 gives 0.
REQ-044 Three back-to-back bursts with no rd_done -> bursts 1 and 2 are stored, burst 3 is dropped, ovf=1; after rd_done, reads return burst-2 data.
REQ-045 40-word burst, then dv_i=0 -> short_err pulses once, win_rdy stays 0; a following full burst is stored intact at addresses 0..129.
REQ-046 rd_done on the same cycle as the last word of burst 2 -> win_rdy stays 1 and reads switch to burst 2 data.
REQ-047 rst asserted at word 70 of a burst, then a fresh full burst -> win_rdy=1 with only the fresh data; ovf=0 and short_err=0.

Source files
------------

// File: rtl/dnn_input_buffer_pkg.sv
// Shared DNN front-end constants: normalizer widths, input-buffer geometry and
// the write-side state encoding of the ping-pong window buffer.
package dnn_input_buffer_pkg;

   localparam int unsigned NORM_IBIT   = 16;
   localparam int unsigned NORM_FRAC   = 8;

   localparam int unsigned DNN_OBIT    = 13;
   localparam int unsigned DNN_INFRAME = 5;
   localparam int unsigned DNN_IDIM    = 26;
   localparam int unsigned DNN_DEPTH   = DNN_INFRAME * DNN_IDIM;
   localparam int unsigned DNN_AW      = 8;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_DROP = 2'd2
   } wr_state_t;

endpackage : dnn_input_buffer_pkg

// File: rtl/dnn_input_buffer_ram.sv
// Simple dual-port window storage: two banks of DEPTH words addressed as
// {bank, word}, one write port and a registered read port with a zeroing option.
module dp_ram_1r1w
   import dnn_input_buffer_pkg::*;
#(
   parameter int unsigned W     = DNN_OBIT,
   parameter int unsigned DEPTH = DNN_DEPTH,
   parameter int unsigned AW    = DNN_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW:0]   i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic          i_rclr,
   input  logic [AW:0]   i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [2][DEPTH];

   // Storage is never reset; only the read register is.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr[AW]][i_waddr[AW-1:0]] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_rdata <= '0;
      end else if (i_re) begin
         o_rdata <= i_rclr ? '0 : r_mem[i_raddr[AW]][i_raddr[AW-1:0]];
      end
   end

endmodule : dp_ram_1r1w

// File: rtl/dnn_input_buffer.sv
// Ping-pong context-window buffer between the feature normalizer and the DNN:
// one bank fills from a DEPTH-word burst while the other is read by the consumer.
module dnn_input_buffer
   import dnn_input_buffer_pkg::*;
#(
   parameter int unsigned OBIT    = DNN_OBIT,
   parameter int unsigned INFRAME = DNN_INFRAME,
   parameter int unsigned IDIM    = DNN_IDIM,
   parameter int unsigned DEPTH   = INFRAME * IDIM,
   parameter int unsigned AW      = DNN_AW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   dv_i,
   input  logic signed [OBIT-1:0] vec_i,
   input  logic [AW-1:0]          rd_addr,
   input  logic                   rd_en,
   output logic signed [OBIT-1:0] rd_data,
   output logic                   win_rdy,
   input  logic                   rd_done,
   output logic                   ovf,
   output logic                   short_err
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   wr_state_t     r_state;
   logic [AW-1:0] r_wr_cnt;
   logic          r_wr_bank;
   logic          r_rd_bank;
   logic [1:0]    r_full;
   logic          r_win_rdy;
   logic          r_ovf;
   logic          r_short_err;

   logic          w_we;
   logic          w_rel;
   logic          w_rd_zero;
   logic [OBIT-1:0] w_rdata;

   // A bank is released only while the consumer actually sees a ready window.
   always_comb begin
      w_we      = dv_i && (r_state != W_DROP) && !r_full[r_wr_bank];
      w_rel     = rd_done && r_win_rdy && r_full[r_rd_bank];
      w_rd_zero = !r_win_rdy || (rd_addr > LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= W_IDLE;
         r_wr_cnt    <= '0;
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_full      <= 2'b00;
         r_win_rdy   <= 1'b0;
         r_ovf       <= 1'b0;
         r_short_err <= 1'b0;
      end else begin
         r_short_err <= 1'b0;
         r_win_rdy   <= r_full[r_rd_bank];

         // Fill and release never target the same bank on one edge.
         if (w_rel) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
         end

         case (r_state)
            W_IDLE, W_FILL: begin
               if (dv_i) begin
                  if (r_full[r_wr_bank]) begin
                     r_ovf    <= 1'b1;
                     r_wr_cnt <= '0;
                     r_state  <= W_DROP;
                  end else if (r_wr_cnt == LAST) begin
                     r_full[r_wr_bank] <= 1'b1;
                     r_wr_bank         <= ~r_wr_bank;
                     r_wr_cnt          <= '0;
                     r_state           <= W_IDLE;
                  end else begin
                     r_wr_cnt <= r_wr_cnt + AW'(1);
                     r_state  <= W_FILL;
                  end
               end else if (r_state == W_FILL) begin
                  r_wr_cnt    <= '0;
                  r_short_err <= 1'b1;
                  r_state     <= W_IDLE;
               end
            end
            W_DROP: begin
               if (!dv_i) begin
                  r_state <= W_IDLE;
               end
            end
            default: r_state <= W_IDLE;
         endcase
      end
   end

   dp_ram_1r1w #(
      .W     (OBIT),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr ({r_wr_bank, r_wr_cnt}),
      .i_wdata (vec_i),
      .i_re    (rd_en),
      .i_rclr  (w_rd_zero),
      .i_raddr ({r_rd_bank, rd_addr}),
      .o_rdata (w_rdata)
   );

   assign rd_data   = w_rdata;
   assign win_rdy   = r_win_rdy;
   assign ovf       = r_ovf;
   assign short_err = r_short_err;

endmodule : dnn_input_buffer
